// File: rtl/match_round_ctrl_if.sv
// Signal bundle between the memory-game UI and match_round_ctrl.
// north is a one-cycle strobe with no ready: acceptance shows up only as a change in choose_1/choose_2.
interface match_round_ctrl_if;
    logic        north;
    logic [4:0]  point;
    logic [47:0] deck;
    logic [4:0]  choose_1;
    logic [4:0]  choose_2;
    logic [15:0] matched;
    logic [15:0] revealed;
    logic [3:0]  pairs_found;
    logic [7:0]  turns;
    logic        game_over;
    logic        win;
    logic [2:0]  fsm_state;

    modport master (
        output north, point, deck,
        input  choose_1, choose_2, matched, revealed, pairs_found, turns,
               game_over, win, fsm_state
    );

    modport slave (
        input  north, point, deck,
        output choose_1, choose_2, matched, revealed, pairs_found, turns,
               game_over, win, fsm_state
    );
endinterface

// File: rtl/match_round_ctrl.sv
// Round controller for a 16-card memory game: selection, pair check, reveal timeout, win.
// Optional macro TURN_LIMIT_EN ends the game after TURN_LIMIT turns.
module match_round_ctrl #(
    parameter int REVEAL_CYCLES = 25_000_000,
    parameter int TURN_LIMIT    = 32
) (
    input logic               new_clk,
    input logic               rst,
    match_round_ctrl_if.slave bus
);
    localparam int              TW         = $clog2(REVEAL_CYCLES) + 1;
    localparam logic [TW-1:0]   TIMER_LOAD = TW'(REVEAL_CYCLES - 1);
    localparam logic [4:0]      NONE       = 5'd16;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ONE   = 3'd1,
        CHECK = 3'd2,
        SHOW  = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t        state_q, state_d;
    logic [4:0]    c1_q, c1_d, c2_q, c2_d;
    logic [15:0]   matched_q, matched_d;
    logic [3:0]    pairs_q, pairs_d;
    logic [7:0]    turns_q, turns_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          over_q, over_d, win_q, win_d;

    logic [2:0]    faces [16];
    logic          point_ok;
    logic          faces_equal;

    always_comb begin
        for (int i = 0; i < 16; i++) faces[i] = bus.deck[3*i +: 3];
    end

    // A selectable card must exist and must not already be paired.
    assign point_ok    = !bus.point[4] && !matched_q[bus.point[3:0]];
    assign faces_equal = faces[c1_q[3:0]] == faces[c2_q[3:0]];

`ifndef TURN_LIMIT_EN
    logic unused_turn_limit;
    assign unused_turn_limit = ^8'(TURN_LIMIT);
`endif

    always_comb begin
        state_d   = state_q;
        c1_d      = c1_q;
        c2_d      = c2_q;
        matched_d = matched_q;
        pairs_d   = pairs_q;
        turns_d   = turns_q;
        timer_d   = timer_q;
        case (state_q)
            IDLE: begin
                if (bus.north && point_ok) begin
                    c1_d    = bus.point;
                    state_d = ONE;
                end
            end
            ONE: begin
                if (bus.north && point_ok && bus.point != c1_q) begin
                    c2_d    = bus.point;
                    state_d = CHECK;
                end
            end
            CHECK: begin
                turns_d = (turns_q == 8'hFF) ? turns_q : turns_q + 8'd1;
                if (faces_equal) begin
                    matched_d = matched_q | (16'b1 << c1_q[3:0]) | (16'b1 << c2_q[3:0]);
                    pairs_d   = pairs_q + 4'd1;
                    c1_d      = NONE;
                    c2_d      = NONE;
                    state_d   = (pairs_d == 4'd8) ? DONE : IDLE;
                end else begin
                    timer_d = TIMER_LOAD;
                    state_d = SHOW;
                end
`ifdef TURN_LIMIT_EN
                // Running out of turns overrides the reveal; the pair result still counts.
                if (turns_d == 8'(TURN_LIMIT) && pairs_d != 4'd8) begin
                    c1_d    = NONE;
                    c2_d    = NONE;
                    timer_d = '0;
                    state_d = DONE;
                end
`endif
            end
            SHOW: begin
                if (timer_q == '0) begin
                    c1_d    = NONE;
                    c2_d    = NONE;
                    state_d = IDLE;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            DONE: begin
            end
            default: state_d = IDLE;
        endcase
        over_d = (state_d == DONE);
        win_d  = (state_d == DONE) && (pairs_d == 4'd8);
    end

    always_ff @(posedge new_clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            c1_q      <= NONE;
            c2_q      <= NONE;
            matched_q <= '0;
            pairs_q   <= '0;
            turns_q   <= '0;
            timer_q   <= '0;
            over_q    <= 1'b0;
            win_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            c1_q      <= c1_d;
            c2_q      <= c2_d;
            matched_q <= matched_d;
            pairs_q   <= pairs_d;
            turns_q   <= turns_d;
            timer_q   <= timer_d;
            over_q    <= over_d;
            win_q     <= win_d;
        end
    end

    always_comb begin
        for (int i = 0; i < 16; i++) begin
            bus.revealed[i] = matched_q[i] | (c1_q == 5'(i)) | (c2_q == 5'(i));
        end
    end

    assign bus.choose_1    = c1_q;
    assign bus.choose_2    = c2_q;
    assign bus.matched     = matched_q;
    assign bus.pairs_found = pairs_q;
    assign bus.turns       = turns_q;
    assign bus.game_over   = over_q;
    assign bus.win         = win_q;
    assign bus.fsm_state   = state_q;
endmodule

// File: tb/tb_match_round_ctrl.sv
// Directed bench for match_round_ctrl with REVEAL_CYCLES=4 and deck face(i)=i>>1.
// With TURN_LIMIT_EN defined the bench uses TURN_LIMIT=2 and runs the turn-limit scenario.
module tb_match_round_ctrl;
    localparam int REVEAL = 4;
`ifdef TURN_LIMIT_EN
    localparam int TL = 2;
`else
    localparam int TL = 32;
`endif
    localparam logic [2:0] S_IDLE = 3'd0, S_ONE = 3'd1, S_CHECK = 3'd2, S_SHOW = 3'd3, S_DONE = 3'd4;

    logic new_clk = 1'b0;
    logic rst     = 1'b0;
    int   checks  = 0;
    int   errors  = 0;

    match_round_ctrl_if bus();

    match_round_ctrl #(.REVEAL_CYCLES(REVEAL), .TURN_LIMIT(TL)) dut (
        .new_clk(new_clk),
        .rst    (rst),
        .bus    (bus)
    );

    always #5 new_clk = ~new_clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    task automatic do_reset();
        @(negedge new_clk);
        rst = 1'b0;
        bus.north = 1'b0;
        bus.point = 5'd16;
        @(negedge new_clk);
        @(negedge new_clk);
        rst = 1'b1;
    endtask

    // One-cycle select strobe; returns on the negedge after the accepting posedge.
    task automatic pulse(input logic [4:0] p);
        @(negedge new_clk);
        bus.north = 1'b1;
        bus.point = p;
        @(negedge new_clk);
        bus.north = 1'b0;
        bus.point = 5'd16;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (bus.choose_1 !== 5'd16) begin errors++; $display("FAIL reset_c1: got %0d want 16", bus.choose_1); end
        checks++; if (bus.choose_2 !== 5'd16) begin errors++; $display("FAIL reset_c2: got %0d want 16", bus.choose_2); end
        checks++; if (bus.matched !== 16'h0) begin errors++; $display("FAIL reset_matched: got %h want 0000", bus.matched); end
        checks++; if (bus.revealed !== 16'h0) begin errors++; $display("FAIL reset_revealed: got %h want 0000", bus.revealed); end
        checks++; if (bus.pairs_found !== 4'd0) begin errors++; $display("FAIL reset_pairs: got %0d want 0", bus.pairs_found); end
        checks++; if (bus.turns !== 8'd0) begin errors++; $display("FAIL reset_turns: got %0d want 0", bus.turns); end
        checks++; if ({bus.game_over, bus.win} !== 2'b00) begin errors++; $display("FAIL reset_over_win: got %b want 00", {bus.game_over, bus.win}); end
        checks++; if (bus.fsm_state !== S_IDLE) begin errors++; $display("FAIL reset_state: got %0d want %0d", bus.fsm_state, S_IDLE); end
    endtask

    task automatic test_match();
        do_reset();
        pulse(5'd0);
        checks++; if (bus.choose_1 !== 5'd0) begin errors++; $display("FAIL match_c1: got %0d want 0", bus.choose_1); end
        checks++; if (bus.fsm_state !== S_ONE) begin errors++; $display("FAIL match_state_one: got %0d want %0d", bus.fsm_state, S_ONE); end
        checks++; if (bus.revealed !== 16'h0001) begin errors++; $display("FAIL match_rev1: got %h want 0001", bus.revealed); end
        pulse(5'd1);
        checks++; if (bus.fsm_state !== S_CHECK) begin errors++; $display("FAIL match_state_check: got %0d want %0d", bus.fsm_state, S_CHECK); end
        checks++; if (bus.revealed !== 16'h0003) begin errors++; $display("FAIL match_rev2: got %h want 0003", bus.revealed); end
        checks++; if (bus.matched !== 16'h0000) begin errors++; $display("FAIL match_early: got %h want 0000", bus.matched); end
        @(negedge new_clk);
        checks++; if (bus.matched !== 16'h0003) begin errors++; $display("FAIL match_matched: got %h want 0003", bus.matched); end
        checks++; if (bus.pairs_found !== 4'd1) begin errors++; $display("FAIL match_pairs: got %0d want 1", bus.pairs_found); end
        checks++; if (bus.turns !== 8'd1) begin errors++; $display("FAIL match_turns: got %0d want 1", bus.turns); end
        checks++; if ({bus.choose_1, bus.choose_2} !== {5'd16, 5'd16}) begin errors++; $display("FAIL match_clear: got %0d/%0d want 16/16", bus.choose_1, bus.choose_2); end
        checks++; if (bus.fsm_state !== S_IDLE) begin errors++; $display("FAIL match_state_idle: got %0d want %0d", bus.fsm_state, S_IDLE); end
    endtask

    task automatic test_mismatch();
        do_reset();
        pulse(5'd0);
        pulse(5'd2);
        checks++; if (bus.revealed !== 16'h0005) begin errors++; $display("FAIL mis_rev_k0: got %h want 0005", bus.revealed); end
        for (int k = 1; k <= REVEAL; k++) begin
            bus.north = (k == 2);
            bus.point = (k == 2) ? 5'd4 : 5'd16;
            @(negedge new_clk);
            checks++; if (bus.revealed !== 16'h0005) begin errors++; $display("FAIL mis_rev_k%0d: got %h want 0005", k, bus.revealed); end
            checks++; if (bus.fsm_state !== S_SHOW) begin errors++; $display("FAIL mis_state_k%0d: got %0d want %0d", k, bus.fsm_state, S_SHOW); end
        end
        bus.north = 1'b0;
        bus.point = 5'd16;
        @(negedge new_clk);
        checks++; if (bus.revealed !== 16'h0000) begin errors++; $display("FAIL mis_hidden: got %h want 0000", bus.revealed); end
        checks++; if (bus.fsm_state !== S_IDLE) begin errors++; $display("FAIL mis_state_idle: got %0d want %0d", bus.fsm_state, S_IDLE); end
        checks++; if (bus.turns !== 8'd1) begin errors++; $display("FAIL mis_turns: got %0d want 1", bus.turns); end
        checks++; if (bus.pairs_found !== 4'd0) begin errors++; $display("FAIL mis_pairs: got %0d want 0", bus.pairs_found); end
    endtask

    task automatic test_ignored();
        do_reset();
        pulse(5'd0);
        pulse(5'd1);
        @(negedge new_clk);
        pulse(5'd0);
        checks++; if (bus.choose_1 !== 5'd16) begin errors++; $display("FAIL ign_idle_matched: got %0d want 16", bus.choose_1); end
        pulse(5'd20);
        checks++; if (bus.fsm_state !== S_IDLE) begin errors++; $display("FAIL ign_idle_nocard: got %0d want %0d", bus.fsm_state, S_IDLE); end
        pulse(5'd5);
        checks++; if (bus.choose_1 !== 5'd5) begin errors++; $display("FAIL ign_c1: got %0d want 5", bus.choose_1); end
        pulse(5'd5);
        checks++; if (bus.choose_2 !== 5'd16) begin errors++; $display("FAIL ign_same: got %0d want 16", bus.choose_2); end
        pulse(5'd0);
        checks++; if (bus.choose_2 !== 5'd16) begin errors++; $display("FAIL ign_matched: got %0d want 16", bus.choose_2); end
        pulse(5'd20);
        checks++; if (bus.choose_2 !== 5'd16) begin errors++; $display("FAIL ign_nocard: got %0d want 16", bus.choose_2); end
        checks++; if (bus.choose_1 !== 5'd5) begin errors++; $display("FAIL ign_c1_kept: got %0d want 5", bus.choose_1); end
        checks++; if (bus.fsm_state !== S_ONE) begin errors++; $display("FAIL ign_state: got %0d want %0d", bus.fsm_state, S_ONE); end
    endtask

    task automatic test_all_pairs();
        do_reset();
        for (int p = 0; p < 8; p++) begin
            pulse(5'(2 * p));
            pulse(5'(2 * p + 1));
            @(negedge new_clk);
            if (p == 6) begin
                checks++; if (bus.game_over !== 1'b0) begin errors++; $display("FAIL all_over_early: got %b want 0", bus.game_over); end
            end
        end
        checks++; if (bus.pairs_found !== 4'd8) begin errors++; $display("FAIL all_pairs: got %0d want 8", bus.pairs_found); end
        checks++; if ({bus.game_over, bus.win} !== 2'b11) begin errors++; $display("FAIL all_over_win: got %b want 11", {bus.game_over, bus.win}); end
        checks++; if (bus.matched !== 16'hFFFF) begin errors++; $display("FAIL all_matched: got %h want ffff", bus.matched); end
        checks++; if (bus.turns !== 8'd8) begin errors++; $display("FAIL all_turns: got %0d want 8", bus.turns); end
        checks++; if (bus.fsm_state !== S_DONE) begin errors++; $display("FAIL all_state: got %0d want %0d", bus.fsm_state, S_DONE); end
        pulse(5'd3);
        @(negedge new_clk);
        checks++; if (bus.choose_1 !== 5'd16) begin errors++; $display("FAIL all_frozen_c1: got %0d want 16", bus.choose_1); end
        checks++; if ({bus.fsm_state, bus.turns} !== {S_DONE, 8'd8}) begin errors++; $display("FAIL all_frozen: got %0d/%0d want %0d/8", bus.fsm_state, bus.turns, S_DONE); end
    endtask

    task automatic test_reset_mid_show();
        do_reset();
        pulse(5'd0);
        pulse(5'd1);
        @(negedge new_clk);
        pulse(5'd0 + 5'd2);
        pulse(5'd4);
        @(negedge new_clk);
        @(negedge new_clk);
        checks++; if (bus.fsm_state !== S_SHOW) begin errors++; $display("FAIL rst_show_pre: got %0d want %0d", bus.fsm_state, S_SHOW); end
        #2;
        rst = 1'b0;
        #1;
        checks++; if (bus.fsm_state !== S_IDLE) begin errors++; $display("FAIL rst_async_state: got %0d want %0d", bus.fsm_state, S_IDLE); end
        checks++; if ({bus.choose_1, bus.choose_2} !== {5'd16, 5'd16}) begin errors++; $display("FAIL rst_async_c: got %0d/%0d want 16/16", bus.choose_1, bus.choose_2); end
        checks++; if ({bus.matched, bus.revealed} !== 32'h0) begin errors++; $display("FAIL rst_async_cards: got %h/%h want 0000/0000", bus.matched, bus.revealed); end
        checks++; if ({bus.pairs_found, bus.turns, bus.game_over, bus.win} !== 14'h0) begin errors++; $display("FAIL rst_async_counts: got %0d/%0d want 0/0", bus.pairs_found, bus.turns); end
        @(negedge new_clk);
        rst = 1'b1;
        bus.north = 1'b1;
        bus.point = 5'd3;
        @(negedge new_clk);
        bus.north = 1'b0;
        checks++; if (bus.choose_1 !== 5'd3) begin errors++; $display("FAIL rst_first_north: got %0d want 3", bus.choose_1); end
        checks++; if (bus.fsm_state !== S_ONE) begin errors++; $display("FAIL rst_first_state: got %0d want %0d", bus.fsm_state, S_ONE); end
    endtask

`ifdef TURN_LIMIT_EN
    task automatic test_turn_limit();
        do_reset();
        pulse(5'd0);
        pulse(5'd2);
        @(negedge new_clk);
        checks++; if ({bus.game_over, bus.turns} !== {1'b0, 8'd1}) begin errors++; $display("FAIL tl_first: got %b/%0d want 0/1", bus.game_over, bus.turns); end
        repeat (REVEAL) @(negedge new_clk);
        checks++; if (bus.fsm_state !== S_IDLE) begin errors++; $display("FAIL tl_idle: got %0d want %0d", bus.fsm_state, S_IDLE); end
        pulse(5'd4);
        pulse(5'd6);
        @(negedge new_clk);
        checks++; if ({bus.game_over, bus.win} !== 2'b10) begin errors++; $display("FAIL tl_over_win: got %b want 10", {bus.game_over, bus.win}); end
        checks++; if (bus.turns !== 8'd2) begin errors++; $display("FAIL tl_turns: got %0d want 2", bus.turns); end
        checks++; if ({bus.choose_1, bus.choose_2} !== {5'd16, 5'd16}) begin errors++; $display("FAIL tl_clear: got %0d/%0d want 16/16", bus.choose_1, bus.choose_2); end
        pulse(5'd8);
        checks++; if ({bus.fsm_state, bus.choose_1} !== {S_DONE, 5'd16}) begin errors++; $display("FAIL tl_frozen: got %0d/%0d want %0d/16", bus.fsm_state, bus.choose_1, S_DONE); end
    endtask
`endif

    initial begin
        bus.north = 1'b0;
        bus.point = 5'd16;
        for (int i = 0; i < 16; i++) bus.deck[3*i +: 3] = 3'(i >> 1);
        test_reset();
        test_match();
        test_mismatch();
        test_ignored();
`ifdef TURN_LIMIT_EN
        test_turn_limit();
`else
        test_all_pairs();
`endif
        test_reset_mid_show();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/match_round_ctrl.md
MATCH_ROUND_CTRL -- requirements
Module: match_round_ctrl

Interface
REQ-001 Parameter: REVEAL_CYCLES, 25_000_000, new_clk cycles a mismatched pair stays face-up (min 1).
REQ-002 Parameter: TURN_LIMIT, 32, turn count that ends the game (used only with TURN_LIMIT_EN).
REQ-003 new_clk  in  1  sole clock, rising edge.
REQ-004 rst  in  1  asynchronous, active-low reset.
REQ-005 north  in  1  select strobe, one new_clk cycle wide, synchronous.
REQ-006 point  in  5  cursor position; 0-15 valid, >=16 means no card.
REQ-007 deck  in  48  face id of card i at deck[3i+2:3i]; held stable during a game.
REQ-008 choose_1  out  5  first selected card; 16 = none.
REQ-009 choose_2  out  5  second selected card; 16 = none.
REQ-010 matched  out  16  bit i set = card i permanently paired.
REQ-011 revealed  out  16  face-up cards: matched[i] | (choose_1==i) | (choose_2==i).
REQ-012 pairs_found  out  4  pairs matched, 0-8.
REQ-013 turns  out  8  completed turns, saturates at 255.
REQ-014 game_over  out  1  high in DONE.
REQ-015 win  out  1  high in DONE when pairs_found==8.

Function
REQ-016 FSM states: IDLE, ONE, CHECK, SHOW, DONE; all outputs registered except revealed.
REQ-017 IDLE: north with point<16 and !matched[point] -> choose_1<=point, go ONE; any other north is ignored.
REQ-018 ONE: north with point<16, point!=choose_1, !matched[point] -> choose_2<=point, go CHECK; any other north is ignored.
REQ-019 CHECK (exactly 1 cycle): turns+1 (saturating); faces equal -> set both matched bits, pairs_found+1, choose_1/choose_2<=16, go DONE if pairs_found becomes 8, else IDLE.
REQ-020 CHECK mismatch -> load timer with REVEAL_CYCLES-1, go SHOW; choose_1/choose_2 held.
REQ-021 SHOW: timer decrements each cycle; on the cycle the timer==0 -> choose_1/choose_2<=16, go IDLE; north ignored throughout.
REQ-022 Mismatch latency: second north to cards hidden = 1 + REVEAL_CYCLES cycles; match latency = 2 cycles to matched bits visible.
REQ-023 DONE: all state frozen, north ignored, exit only via rst.
REQ-024 Timer width = ceil(log2(REVEAL_CYCLES))+1 bits; no wrap.
REQ-025 north in CHECK is ignored (not queued).

Reset
REQ-026 rst low, at any time including mid-SHOW -> state IDLE, choose_1=choose_2=16, matched=0, pairs_found=0, turns=0, timer=0, game_over=0, win=0, immediately and asynchronously.
REQ-027 Release of rst takes effect synchronously; first north accepted on the first new_clk edge after rst goes high.

Configuration
REQ-028 Macro TURN_LIMIT_EN defined: in CHECK, if updated turns==TURN_LIMIT and pairs_found<8 after update -> go DONE with game_over=1, win=0, choose_1/choose_2<=16 (match result of that turn still applied).
REQ-029 TURN_LIMIT_EN undefined: no turn limit; DONE reached only by 8 pairs; TURN_LIMIT unused.

Verification (REVEAL_CYCLES=4, deck face(i)=i>>1)
REQ-030 Reset then north@point=0, north@point=1 -> matched=0x0003, pairs_found=1, turns=1, choose_1=choose_2=16, state IDLE.
REQ-031 north@0, north@2 -> revealed=0x0005 for 5 cycles after second north, then 0x0000; turns=1; north during SHOW ignored.
REQ-032 north@5 twice, north@0 after 0/1 matched, north@20 -> all ignored, choose_2 stays 16 / choose_1 unaffected.
REQ-033 Match all 8 pairs in order -> pairs_found=8, game_over=1, win=1, further north no effect.
REQ-034 rst low 2 cycles into SHOW -> all outputs at reset values at once; next north@3 accepted as choose_1.
REQ-035 TURN_LIMIT_EN, TURN_LIMIT=2: two mismatched turns -> game_over=1, win=0 after second CHECK, turns=2.
